// File: rtl/mult_slave_pkg.sv
// Shared constants and types for the AXI4-Lite multiplier slave:
// register offsets, status bit positions, response code and core FSM states.
package mult_slave_pkg;

  localparam logic [1:0] ADDR_OPA    = 2'd0;
  localparam logic [1:0] ADDR_OPB    = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int STAT_BUSY_BIT   = 1;
  localparam int STAT_DONE_BIT   = 2;
  localparam int STAT_OVRUN_BIT  = 3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Byte-lane merge of a write into an existing 32-bit register image
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_val[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// OP_WIDTH cycles per multiply; done/product are valid on the last RUN cycle.
module mult_shift_add
  import mult_slave_pkg::*;
#(
  parameter int OP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [OP_WIDTH-1:0]     op_a,
  input  logic [OP_WIDTH-1:0]     op_b,
  output logic                    busy,
  output logic                    done,
  output logic [2*OP_WIDTH-1:0]   product
);

  localparam int PW = 2 * OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(OP_WIDTH - 1);

  state_t                state_r;
  logic [PW-1:0]         mcand_r;
  logic [PW-1:0]         acc_r;
  logic [OP_WIDTH-1:0]   mplier_r;
  logic [CW-1:0]         cnt_r;
  logic [PW-1:0]         partial_s;
  logic [PW-1:0]         acc_next_s;

  // Partial product for the current multiplier bit and the running sum
  always_comb begin
    partial_s  = {PW{1'b0}};
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      partial_s = mcand_r;
    end else begin
      partial_s = {PW{1'b0}};
    end
    acc_next_s = acc_r + partial_s;
  end

  assign busy    = (state_r == RUN);
  assign done    = (state_r == RUN) && (cnt_r == LAST_CNT);
  assign product = acc_next_s;

  // Multiply FSM: operands are captured on start and never re-read while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      mcand_r  <= {PW{1'b0}};
      acc_r    <= {PW{1'b0}};
      mplier_r <= {OP_WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= PW'(op_a);
            mplier_r <= op_b;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            state_r  <= RUN;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_mult_slave.sv
// AXI4-Lite register front end (OPA, OPB, RESULT, CTRL/STAT) around mult_shift_add.
// Define MULT_AUTOSTART_EN to make an OPB write in IDLE also start a multiply.
module axi_lite_mult_slave
  import mult_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int OP_WIDTH           = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  logic                   awready_r, wready_r, bvalid_r;
  logic                   arready_r, rvalid_r;
  logic [31:0]            rdata_r;
  logic [OP_WIDTH-1:0]    opa_r, opb_r;
  logic [31:0]            result_r;
  logic                   done_r, overrun_r;

  logic                   wr_en_s, rd_en_s;
  logic [1:0]             wr_idx_s, rd_idx_s;
  logic [31:0]            opa_wr_s, opb_wr_s, ctrl_wr_s, rd_data_s;
  logic                   start_req_s, core_start_s, overrun_set_s;
  logic                   clr_done_s, clr_ovrun_s;
  logic [OP_WIDTH-1:0]    core_op_b_s;
  logic                   core_busy_s, core_done_s;
  logic [2*OP_WIDTH-1:0]  core_product_s;
  logic                   unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_en_s   = awready_r && wready_r && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en_s   = arready_r && S_AXI_ARVALID;
  assign wr_idx_s  = S_AXI_AWADDR[3:2];
  assign rd_idx_s  = S_AXI_ARADDR[3:2];
  assign opa_wr_s  = apply_wstrb(32'(opa_r), S_AXI_WDATA, S_AXI_WSTRB);
  assign opb_wr_s  = apply_wstrb(32'(opb_r), S_AXI_WDATA, S_AXI_WSTRB);
  assign ctrl_wr_s = apply_wstrb(32'h0000_0000, S_AXI_WDATA, S_AXI_WSTRB);

  // Start/overrun decode; a request landing while the core runs only flags OVERRUN
  always_comb begin
    start_req_s   = 1'b0;
    core_op_b_s   = opb_r;
    clr_done_s    = 1'b0;
    clr_ovrun_s   = 1'b0;
    if (wr_en_s && (wr_idx_s == ADDR_CTRL)) begin
      start_req_s = ctrl_wr_s[CTRL_START_BIT];
      clr_done_s  = ctrl_wr_s[STAT_DONE_BIT];
      clr_ovrun_s = ctrl_wr_s[STAT_OVRUN_BIT];
`ifdef MULT_AUTOSTART_EN
    end else if (wr_en_s && (wr_idx_s == ADDR_OPB)) begin
      start_req_s = 1'b1;
      core_op_b_s = opb_wr_s[OP_WIDTH-1:0];
`endif
    end else begin
      start_req_s = 1'b0;
    end
    core_start_s  = start_req_s && !core_busy_s;
    overrun_set_s = start_req_s && core_busy_s;
  end

  mult_shift_add #(.OP_WIDTH(OP_WIDTH)) u_core (
    .clk     (ACLK),
    .rst     (ARESET),
    .start   (core_start_s),
    .op_a    (opa_r),
    .op_b    (core_op_b_s),
    .busy    (core_busy_s),
    .done    (core_done_s),
    .product (core_product_s)
  );

  // Write address/data handshake: one-cycle ready pulse, response held until BREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      awready_r <= S_AXI_AWVALID && S_AXI_WVALID && !awready_r && !bvalid_r;
      wready_r  <= S_AXI_AWVALID && S_AXI_WVALID && !awready_r && !bvalid_r;
      if (wr_en_s) begin
        bvalid_r <= 1'b1;
      end else if (bvalid_r && S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // Operand registers; RESULT is read-only so its offset falls through
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      opa_r <= {OP_WIDTH{1'b0}};
      opb_r <= {OP_WIDTH{1'b0}};
    end else if (wr_en_s) begin
      case (wr_idx_s)
        ADDR_OPA: opa_r <= opa_wr_s[OP_WIDTH-1:0];
        ADDR_OPB: opb_r <= opb_wr_s[OP_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  // Result capture and sticky status; a completing multiply wins over a W1C clear
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      result_r  <= 32'h0000_0000;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (core_done_s) begin
        result_r <= 32'(core_product_s);
      end
      if (core_done_s) begin
        done_r <= 1'b1;
      end else if (core_start_s || clr_done_s) begin
        done_r <= 1'b0;
      end
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (clr_ovrun_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Read mux; START is self-clearing so bit0 always reads 0
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (rd_idx_s)
      ADDR_OPA:    rd_data_s = 32'(opa_r);
      ADDR_OPB:    rd_data_s = 32'(opb_r);
      ADDR_RESULT: rd_data_s = result_r;
      ADDR_CTRL: begin
        rd_data_s[STAT_BUSY_BIT]  = core_busy_s;
        rd_data_s[STAT_DONE_BIT]  = done_r;
        rd_data_s[STAT_OVRUN_BIT] = overrun_r;
      end
      default:     rd_data_s = 32'h0000_0000;
    endcase
  end

  // Read handshake; RDATA only loads on acceptance so it stays put while RVALID is high
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      arready_r <= S_AXI_ARVALID && !arready_r && !rvalid_r;
      if (rd_en_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
      end else if (rvalid_r && S_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: doc/axi_lite_mult_slave.md
Name: axi_lite_mult_slave

Overview:
AXI4-Lite slave that exposes a 4-register multiplier to an AXI4-Lite master such as the BFM master in the block design. Holds two operands, runs an iterative shift-add multiply when started, and exposes result and status for readback. Sits directly on the S00_AXI port of the multiplier IP, inside the BD wrapper that the BFM bench drives.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 word registers.
OP_WIDTH, 16, operand width; product is 2*OP_WIDTH bits and must be <= 32.

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00 (OKAY)
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Clocking and reset: one clock, ACLK. ARESET is asynchronous, active-high. While ARESET is high, every output and every register is 0, and the FSM is IDLE. Reset mid-multiply aborts the multiply with no residue.
- Register map, decoded from addr[3:2]:
  - 0x0 OPA: RW. Bits [OP_WIDTH-1:0] are stored; upper bits read as 0.
  - 0x4 OPB: RW, same width rule as OPA.
  - 0x8 RESULT: RO. Writes are ignored and still return OKAY.
  - 0xC CTRL/STAT: writing bit0=1 is START, which is self-clearing and reads as 0. Read bits: bit1 BUSY, bit2 DONE (sticky), bit3 OVERRUN (sticky). Writing 1 to bit2 or bit3 clears that bit.
- WSTRB applies per byte on OPA, OPB and CTRL writes.
- Write channel:
  - AWREADY and WREADY pulse high together for 1 cycle when AWVALID && WVALID && !AWREADY && !BVALID.
  - The register updates on that handshake edge.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID is high.
- Read channel:
  - ARREADY pulses for 1 cycle when ARVALID && !ARREADY && !RVALID.
  - RDATA is registered, and RVALID rises the next cycle and holds until RREADY.
  - RDATA is stable while RVALID is high.
- Simultaneous read and write: processed independently. A read in the same cycle as a write to the same register returns the old value.
- FSM:
  - IDLE: on START, latch OPA/OPB into the core, clear DONE, go to RUN.
  - RUN: lasts exactly OP_WIDTH cycles with BUSY=1. On the last cycle, write the product to RESULT, set DONE, go to IDLE.
  - BUSY is first visible on the cycle after the START write handshake.
  - START while RUN is ignored and sets OVERRUN; the running multiply is unaffected.
  - Writes to OPA/OPB during RUN update the registers only; they do not affect the running multiply.
- Arithmetic: unsigned. The product is 2*OP_WIDTH bits, zero-extended to 32.

Optional Feature:
MULT_AUTOSTART_EN
- Defined: a write handshake to OPB in IDLE also acts as START, using the new OPB value and the current OPA. A write to OPB during RUN sets OVERRUN.
- Undefined: multiplication starts only via the CTRL START bit.

Decomposition:
- Package mult_slave_pkg holds:
  - register offset constants (ADDR_OPA/OPB/RESULT/CTRL);
  - CTRL/STAT bit positions;
  - the RESP_OKAY constant;
  - the FSM state typedef (IDLE, RUN).
- Sub-module mult_shift_add holds the iterative core: start, operands, busy, done pulse, product. The AXI register/handshake logic stays in the top.

Test Plan:
1. After reset, read 0x0/0x4/0x8/0xC -> all 0x00000000, RRESP=OKAY.
2. Write OPA=0x0101FFFF, read OPA -> 0x0000FFFF (upper bits dropped). Write OPB=0x00000101, START. Poll STAT: BUSY for exactly 16 cycles, then DONE=1. RESULT=0x0100FEFF.
3. OPA=0xABCD, OPB=0x0001 -> RESULT=0x0000ABCD. OPA=0xDEAD, OPB=0xBEEF -> RESULT=0xA6144983.
4. OPA=0x0000FFFF, write 0x12345678 with WSTRB=4'b0001 -> read 0x0000FF78. Write RESULT=0xBEEF0011 -> BRESP=OKAY and RESULT unchanged.
5. START again during BUSY -> OVERRUN=1 and RESULT is from the first operands. Write 0x8 to CTRL -> OVERRUN=0. Assert ARESET mid-RUN -> BUSY/DONE/RESULT all 0 immediately.
6. Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA held stable and no new AW/AR accepted. With MULT_AUTOSTART_EN, an OPB write alone -> BUSY on the next cycle.
